gf2_slice_reducer: RTL and testbench

//  Downstream stage of the GF(2) partial-product XOR trees. Each tree emits one DW-bit slice of a

---
 rtl/gf2_slice_reducer_if.sv | 31 +++
 rtl/gf2_slice_reducer.sv | 110 +++++++++++
 tb/tb_gf2_slice_reducer.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/gf2_slice_reducer_if.sv
// Handshake bundle between the XOR-tree slice producer and the GF(2) reducer.
// The slave modport is the reducer's view; the master modport drives beats
// into it and consumes the reduced field element.
interface gf2_slice_reducer_if #(
    parameter int DW    = 7,
    parameter int LANES = 2,
    parameter int LW    = (LANES > 1) ? $clog2(LANES) : 1
);
    localparam int ACC_W = DW * LANES;

    logic             in_valid;
    logic             in_ready;
    logic [DW-1:0]    in_data;
    logic [LW-1:0]    in_lane;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [DW-1:0]    out_data;
    logic [ACC_W-1:0] out_raw;
    logic             busy;

    modport slave (
        input  in_valid, in_data, in_lane, in_last, out_ready,
        output in_ready, out_valid, out_data, out_raw, busy
    );

    modport master (
        output in_valid, in_data, in_lane, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_raw, busy
    );
endinterface

// File: rtl/gf2_slice_reducer.sv
// GF(2) slice accumulator and sequential modular reducer.
// Slices are XOR-accumulated into an ACC_W-bit carry-less product. After the
// last beat the product is reduced modulo POLY one bit per cycle, from the
// top bit down to bit DW, then the DW-bit remainder is presented until taken.
module gf2_slice_reducer #(
    parameter int          DW    = 7,
    parameter int          LANES = 2,
    parameter logic [DW:0] POLY  = 8'h83,
    parameter int          LW    = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    gf2_slice_reducer_if.slave      bus
);
    localparam int ACC_W = DW * LANES;
    localparam int CW    = $clog2(ACC_W);

    typedef enum logic [1:0] {
        ST_ACC = 2'd0,
        ST_RED = 2'd1,
        ST_OUT = 2'd2
    } state_t;

    state_t           state_r;
    logic [ACC_W-1:0] acc_r;
    logic [ACC_W-1:0] out_raw_r;
    logic [DW-1:0]    out_data_r;
    logic [CW-1:0]    red_cnt_r;
    logic [ACC_W-1:0] beat_term_s;
    logic [ACC_W-1:0] red_acc_s;

    // Position a slice within the product; lanes past the top contribute nothing.
    function automatic logic [ACC_W-1:0] lane_term(input logic [DW-1:0] data,
                                                    input logic [LW-1:0] lane);
        logic [ACC_W-1:0] term;
        if (int'(lane) < LANES) begin
            term = ACC_W'(data) << (int'(lane) * DW);
        end else begin
            term = '0;
        end
        return term;
    endfunction

    // One reduction step: cancel bit cnt with the polynomial aligned under it.
    function automatic logic [ACC_W-1:0] red_step(input logic [ACC_W-1:0] a,
                                                   input logic [CW-1:0]    cnt);
        logic [ACC_W-1:0] poly_ext;
        logic [ACC_W-1:0] res;
        poly_ext = ACC_W'(POLY);
        if (a[cnt]) begin
            res = a ^ (poly_ext << (int'(cnt) - DW));
        end else begin
            res = a;
        end
        return res;
    endfunction

    // Combinational next values for the accumulate and reduce datapaths.
    always_comb begin
        beat_term_s = lane_term(bus.in_data, bus.in_lane);
        red_acc_s   = red_step(acc_r, red_cnt_r);
    end

    // Control FSM with accumulator, reduction counter and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_ACC;
            acc_r      <= '0;
            out_raw_r  <= '0;
            out_data_r <= '0;
            red_cnt_r  <= '0;
        end else begin
            case (state_r)
                ST_ACC: begin
                    if (bus.in_valid) begin
                        acc_r <= acc_r ^ beat_term_s;
                        if (bus.in_last) begin
                            out_raw_r <= acc_r ^ beat_term_s;
                            red_cnt_r <= CW'(ACC_W - 1);
                            state_r   <= ST_RED;
                        end
                    end
                end
                ST_RED: begin
                    acc_r     <= red_acc_s;
                    red_cnt_r <= red_cnt_r - CW'(1);
                    if (red_cnt_r == CW'(DW)) begin
                        out_data_r <= red_acc_s[DW-1:0];
                        state_r    <= ST_OUT;
                    end
                end
                ST_OUT: begin
                    if (bus.out_ready) begin
                        acc_r   <= '0;
                        state_r <= ST_ACC;
                    end
                end
                default: begin
                    state_r <= ST_ACC;
                end
            endcase
        end
    end

    assign bus.in_ready  = (state_r == ST_ACC);
    assign bus.out_valid = (state_r == ST_OUT);
    assign bus.busy      = (state_r != ST_ACC);
    assign bus.out_data  = out_data_r;
    assign bus.out_raw   = out_raw_r;
endmodule

// File: tb/tb_gf2_slice_reducer.sv
// Directed bench for gf2_slice_reducer: hand-computed GF(2^7) remainders,
// latency, output hold under backpressure and mid-reduction reset.
module tb_gf2_slice_reducer;
    localparam int DW    = 7;
    localparam int LANES = 2;
    localparam int LW    = 1;
    localparam int ACC_W = DW * LANES;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    gf2_slice_reducer_if #(.DW(DW), .LANES(LANES), .LW(LW)) bus ();

    gf2_slice_reducer #(.DW(DW), .LANES(LANES), .POLY(8'h83), .LW(LW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Present one beat; in ACC it is accepted on the next rising edge.
    task automatic send_beat(input logic [DW-1:0] data, input logic [LW-1:0] lane,
                             input logic last);
        bus.in_valid = 1'b1;
        bus.in_data  = data;
        bus.in_lane  = lane;
        bus.in_last  = last;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    // Wait (bounded) for the result, check latency and values, then take it.
    task automatic take_result(input string tag, input logic [DW-1:0] exp_data,
                               input logic [ACC_W-1:0] exp_raw, input logic do_take);
        int edges;
        edges = 1;
        while (!bus.out_valid && edges < 30) begin
            @(posedge clk); #1;
            edges++;
        end
        check({tag, "_latency"}, 32'(edges), 32'd8);
        check({tag, "_data"}, 32'(bus.out_data), 32'(exp_data));
        check({tag, "_raw"}, 32'(bus.out_raw), 32'(exp_raw));
        if (do_take) begin
            bus.out_ready = 1'b1;
            @(posedge clk); #1;
            bus.out_ready = 1'b0;
            check({tag, "_valid_drop"}, 32'(bus.out_valid), 32'd0);
            check({tag, "_ready_back"}, 32'(bus.in_ready), 32'd1);
        end
    endtask

    initial begin
        errors        = 0;
        checks        = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 7'h00;
        bus.in_lane   = 1'b0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_out_data", 32'(bus.out_data), 32'd0);
        check("rst_out_raw", 32'(bus.out_raw), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // T1: low-lane only product, already reduced.
        send_beat(7'h55, 1'b0, 1'b0);
        send_beat(7'h00, 1'b1, 1'b1);
        take_result("t1", 7'h55, 14'h0055, 1'b1);

        // T2: x^7 = x + 1.
        send_beat(7'h01, 1'b1, 1'b1);
        take_result("t2", 7'h03, 14'h0080, 1'b1);

        // T3: x^13 = x^6 + x + 1.
        send_beat(7'h40, 1'b1, 1'b1);
        take_result("t3", 7'h43, 14'h2000, 1'b1);

        // T4: repeated lane cancels itself.
        send_beat(7'h0F, 1'b0, 1'b0);
        send_beat(7'h0F, 1'b0, 1'b1);
        take_result("t4", 7'h00, 14'h0000, 1'b1);

        // Both lanes populated: 0x2A<<7 ^ 0x55 -> 0x7E ^ 0x55.
        send_beat(7'h55, 1'b0, 1'b0);
        send_beat(7'h2A, 1'b1, 1'b1);
        take_result("mix", 7'h2B, 14'h1555, 1'b1);

        // Repeated high lane: 0x01 ^ 0x03 = 0x02 in lane1 -> x^8 = x^2 + x.
        send_beat(7'h01, 1'b1, 1'b0);
        send_beat(7'h03, 1'b1, 1'b1);
        take_result("rep", 7'h06, 14'h0100, 1'b1);

        // T5: x^7..x^13 all set -> remainder 0x02; hold under backpressure.
        send_beat(7'h7F, 1'b1, 1'b1);
        take_result("t5", 7'h02, 14'h3F80, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("t5_hold_data", 32'(bus.out_data), 32'h02);
            check("t5_hold_valid", 32'(bus.out_valid), 32'd1);
            check("t5_hold_in_ready", 32'(bus.in_ready), 32'd0);
            check("t5_hold_busy", 32'(bus.busy), 32'd1);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check("t5_valid_drop", 32'(bus.out_valid), 32'd0);
        check("t5_in_ready", 32'(bus.in_ready), 32'd1);

        // T6: reset in the third RED cycle aborts the product.
        send_beat(7'h33, 1'b1, 1'b1);
        repeat (2) @(posedge clk);
        #3;
        check("t6_busy_before", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", 32'(bus.out_valid), 32'd0);
        check("t6_rst_busy", 32'(bus.busy), 32'd0);
        check("t6_rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("t6_rst_data", 32'(bus.out_data), 32'd0);
        check("t6_rst_raw", 32'(bus.out_raw), 32'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        send_beat(7'h12, 1'b0, 1'b1);
        take_result("t6_next", 7'h12, 14'h0012, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
